// File: rtl/uart_receiver.sv
// 8E1 UART receiver with 16x oversampling, 2-flop line synchronizer and
// a baud rate that is selectable per frame.
module uart_receiver #(
   parameter int CLK_HZ = 25000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       Rx_EN,
   input  logic [2:0] baud_select,
   input  logic       RxD,
   output logic [7:0] Rx_DATA,
   output logic       Rx_VALID,
   output logic       Rx_PERROR,
   output logic       Rx_FERROR,
   output logic       Rx_BUSY
);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   // Clocks per sample tick, rounded to nearest: (CLK + 8*baud) / (16*baud).
   function automatic logic [15:0] div_for(input logic [2:0] code);
      int baud;
      case (code)
         3'd0:    baud = 300;
         3'd1:    baud = 1200;
         3'd2:    baud = 4800;
         3'd3:    baud = 9600;
         3'd4:    baud = 19200;
         3'd5:    baud = 38400;
         3'd6:    baud = 57600;
         default: baud = 115200;
      endcase
      return 16'((CLK_HZ + 8 * baud) / (16 * baud));
   endfunction

   state_t      state_q, state_d;
   logic        sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
   logic [15:0] div_q, div_d, tick_cnt_q, tick_cnt_d;
   logic [3:0]  samp_cnt_q, samp_cnt_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shift_q, shift_d, data_q, data_d;
   logic        par_err_q, par_err_d;
   logic        valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d, busy_q, busy_d;
   logic        tick, fall;

   assign tick = (tick_cnt_q == div_q - 16'd1);
   assign fall = prev_q & ~sync2_q;

   always_comb begin
      state_d    = state_q;
      sync1_d    = RxD;
      sync2_d    = sync1_q;
      prev_d     = sync2_q;
      div_d      = div_q;
      tick_cnt_d = tick_cnt_q;
      samp_cnt_d = samp_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      par_err_d  = par_err_q;
      data_d     = data_q;
      valid_d    = 1'b0;
      perr_d     = 1'b0;
      ferr_d     = 1'b0;

      if (state_q != IDLE) begin
         tick_cnt_d = tick ? 16'd0 : tick_cnt_q + 16'd1;
         if (tick) samp_cnt_d = samp_cnt_q + 4'd1;
      end

      case (state_q)
         IDLE: begin
            if (Rx_EN && fall) begin
               state_d    = START;
               div_d      = div_for(baud_select);
               tick_cnt_d = 16'd0;
               samp_cnt_d = 4'd0;
            end
         end
         START: begin
            // Mid start bit: a line that is high again was only a glitch.
            if (tick && samp_cnt_q == 4'd7) begin
               samp_cnt_d = 4'd0;
               bit_cnt_d  = 3'd0;
               state_d    = sync2_q ? IDLE : DATA;
            end
         end
         DATA: begin
            if (tick && samp_cnt_q == 4'd15) begin
               shift_d   = {sync2_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = PARITY;
            end
         end
         PARITY: begin
            if (tick && samp_cnt_q == 4'd15) begin
               par_err_d = ^shift_q ^ sync2_q;
               state_d   = STOP;
            end
         end
         STOP: begin
            if (tick && samp_cnt_q == 4'd15) begin
               state_d = IDLE;
               perr_d  = par_err_q;
               ferr_d  = ~sync2_q;
               if (!par_err_q && sync2_q) begin
                  valid_d = 1'b1;
                  data_d  = shift_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Disabling abandons the frame silently.
      if (!Rx_EN) begin
         state_d = IDLE;
         valid_d = 1'b0;
         perr_d  = 1'b0;
         ferr_d  = 1'b0;
         data_d  = data_q;
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         prev_q     <= 1'b1;
         div_q      <= 16'd0;
         tick_cnt_q <= 16'd0;
         samp_cnt_q <= 4'd0;
         bit_cnt_q  <= 3'd0;
         shift_q    <= 8'h00;
         par_err_q  <= 1'b0;
         data_q     <= 8'h00;
         valid_q    <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         prev_q     <= prev_d;
         div_q      <= div_d;
         tick_cnt_q <= tick_cnt_d;
         samp_cnt_q <= samp_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         par_err_q  <= par_err_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         busy_q     <= busy_d;
      end
   end

   assign Rx_DATA   = data_q;
   assign Rx_VALID  = valid_q;
   assign Rx_PERROR = perr_q;
   assign Rx_FERROR = ferr_q;
   assign Rx_BUSY   = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: good frames, parity/framing errors,
// glitch rejection, enable drop and mid-frame reset.
module tb_uart_receiver;

   localparam int DIV [0:7] = '{5208, 1302, 326, 163, 81, 41, 27, 14};

   logic       clk = 1'b0;
   logic       reset;
   logic       Rx_EN;
   logic [2:0] baud_select;
   logic       RxD;
   logic [7:0] Rx_DATA;
   logic       Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_BUSY;

   int n_chk = 0;
   int n_fail = 0;

   int n_valid = 0, n_perr = 0, n_ferr = 0, n_busy = 0;
   logic [7:0] byte_log [$];

   uart_receiver #(.CLK_HZ(25000000)) dut (
      .clk(clk), .reset(reset), .Rx_EN(Rx_EN), .baud_select(baud_select), .RxD(RxD),
      .Rx_DATA(Rx_DATA), .Rx_VALID(Rx_VALID), .Rx_PERROR(Rx_PERROR),
      .Rx_FERROR(Rx_FERROR), .Rx_BUSY(Rx_BUSY)
   );

   always #5 clk = ~clk;

   // Pulse counters: a pulse wider than one cycle shows up as an extra count.
   always @(negedge clk) begin
      if (Rx_VALID) begin
         n_valid++;
         byte_log.push_back(Rx_DATA);
      end
      if (Rx_PERROR) n_perr++;
      if (Rx_FERROR) n_ferr++;
      if (Rx_BUSY) n_busy++;
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_bit(input logic b, input int code);
      RxD = b;
      idle(16 * DIV[code]);
   endtask

   // baud_select is scrambled after the start bit: the receiver must keep
   // the rate it latched at frame start.
   task automatic send_frame(input int code, input logic [7:0] d, input logic par,
                             input logic stp);
      baud_select = 3'(code);
      drive_bit(1'b0, code);
      baud_select = 3'(code) ^ 3'b101;
      for (int i = 0; i < 8; i++) drive_bit(d[i], code);
      drive_bit(par, code);
      drive_bit(stp, code);
      RxD = 1'b1;
   endtask

   int v0, p0, f0, b0, idx0;
   int got0, got1;

   initial begin
      reset = 1'b1;
      Rx_EN = 1'b0;
      RxD = 1'b1;
      baud_select = 3'd7;
      idle(3);
      check("reset_data", Rx_DATA, 8'h00);
      check("reset_valid", Rx_VALID, 0);
      check("reset_perr", Rx_PERROR, 0);
      check("reset_ferr", Rx_FERROR, 0);
      check("reset_busy", Rx_BUSY, 0);
      reset = 1'b0;
      Rx_EN = 1'b1;
      idle(20);

      // Good frame at 115200
      v0 = n_valid; p0 = n_perr; f0 = n_ferr;
      send_frame(7, 8'hA5, 1'b0, 1'b1);
      idle(50);
      check("a5_valid", n_valid - v0, 1);
      check("a5_data", Rx_DATA, 8'hA5);
      check("a5_noerr", (n_perr - p0) + (n_ferr - f0), 0);
      check("a5_busy_idle", Rx_BUSY, 0);

      // Wrong parity at 9600
      v0 = n_valid; p0 = n_perr; f0 = n_ferr;
      send_frame(3, 8'h01, 1'b0, 1'b1);
      idle(500);
      check("perr_pulse", n_perr - p0, 1);
      check("perr_novalid", n_valid - v0, 0);
      check("perr_noferr", n_ferr - f0, 0);
      check("perr_data_kept", Rx_DATA, 8'hA5);

      // Framing error then recovery
      v0 = n_valid; p0 = n_perr; f0 = n_ferr;
      send_frame(7, 8'h3C, 1'b0, 1'b0);
      idle(2 * 16 * DIV[7]);
      check("ferr_pulse", n_ferr - f0, 1);
      check("ferr_noperr", n_perr - p0, 0);
      check("ferr_novalid", n_valid - v0, 0);
      check("ferr_data_kept", Rx_DATA, 8'hA5);
      v0 = n_valid;
      send_frame(7, 8'h55, 1'b0, 1'b1);
      idle(50);
      check("after_ferr_valid", n_valid - v0, 1);
      check("after_ferr_data", Rx_DATA, 8'h55);

      // Start-bit glitch of 4 sample ticks
      v0 = n_valid; p0 = n_perr; f0 = n_ferr; b0 = n_busy;
      baud_select = 3'd7;
      RxD = 1'b0;
      idle(4 * DIV[7]);
      RxD = 1'b1;
      idle(16 * DIV[7]);
      check("glitch_busy_seen", int'(n_busy > b0), 1);
      check("glitch_busy_low", Rx_BUSY, 0);
      check("glitch_no_pulse", (n_valid - v0) + (n_perr - p0) + (n_ferr - f0), 0);

      // Drop enable during data bit 4
      v0 = n_valid; p0 = n_perr; f0 = n_ferr;
      baud_select = 3'd7;
      drive_bit(1'b0, 7);
      for (int i = 0; i < 4; i++) drive_bit(1'b1, 7);
      RxD = 1'b1;
      idle(8 * DIV[7]);
      check("en_drop_busy_before", Rx_BUSY, 1);
      Rx_EN = 1'b0;
      idle(1);
      check("en_drop_busy_after", Rx_BUSY, 0);
      idle(16 * 16 * DIV[7]);
      check("en_drop_no_pulse", (n_valid - v0) + (n_perr - p0) + (n_ferr - f0), 0);
      check("en_drop_data_kept", Rx_DATA, 8'h55);
      Rx_EN = 1'b1;
      idle(20);
      v0 = n_valid;
      send_frame(7, 8'hFF, 1'b0, 1'b1);
      idle(50);
      check("reenable_valid", n_valid - v0, 1);
      check("reenable_data", Rx_DATA, 8'hFF);

      // Reset in the middle of 0x81, then back-to-back frames
      v0 = n_valid; p0 = n_perr; f0 = n_ferr;
      baud_select = 3'd7;
      drive_bit(1'b0, 7);
      drive_bit(1'b1, 7);
      drive_bit(1'b0, 7);
      RxD = 1'b0;
      idle(100);
      check("rst_busy_before", Rx_BUSY, 1);
      reset = 1'b1;
      #1;
      check("rst_data_now", Rx_DATA, 8'h00);
      check("rst_busy_now", Rx_BUSY, 0);
      check("rst_valid_now", Rx_VALID, 0);
      RxD = 1'b1;
      idle(5);
      reset = 1'b0;
      idle(50);
      check("rst_no_pulse", (n_valid - v0) + (n_perr - p0) + (n_ferr - f0), 0);
      v0 = n_valid; idx0 = byte_log.size();
      send_frame(7, 8'h12, 1'b0, 1'b1);
      send_frame(7, 8'h34, 1'b1, 1'b1);
      idle(50);
      check("b2b_count", n_valid - v0, 2);
      got0 = (byte_log.size() > idx0) ? int'(byte_log[idx0]) : -1;
      got1 = (byte_log.size() > idx0 + 1) ? int'(byte_log[idx0 + 1]) : -1;
      check("b2b_first", got0, 8'h12);
      check("b2b_second", got1, 8'h34);
      check("b2b_data", Rx_DATA, 8'h34);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter: CLK_HZ, 25000000, system clock frequency in Hz; divisor table derived from it.
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 Rx_EN  input  1  receiver enable; 0 = ignore line, abort any frame.
REQ-005 baud_select  input  3  baud code: 0=300, 1=1200, 2=4800, 3=9600, 4=19200, 5=38400, 6=57600, 7=115200.
REQ-006 RxD  input  1  asynchronous serial line, idle high.
REQ-007 Rx_DATA  output  8  last correctly received byte.
REQ-008 Rx_VALID  output  1  one-cycle pulse, new byte on Rx_DATA.
REQ-009 Rx_PERROR  output  1  one-cycle pulse, parity mismatch.
REQ-010 Rx_FERROR  output  1  one-cycle pulse, stop bit sampled 0.
REQ-011 Rx_BUSY  output  1  high while a frame is in progress.

Function
REQ-012 Frame SHALL be: 1 start (0), 8 data LSB first, 1 even-parity bit, 1 stop (1).
REQ-013 Sample tick SHALL pulse one cycle every D clocks, D = round(CLK_HZ/(16*baud)); at 25 MHz D = 5208, 1302, 326, 163, 81, 41, 27, 14 for codes 0..7.
REQ-014 Tick counter SHALL run from 0 to D-1 and wrap; it SHALL restart at 0 on frame start.
REQ-015 RxD SHALL pass through a 2-flop synchronizer; all decisions use synchronized value.
REQ-016 baud_select SHALL be latched on frame start; changes mid-frame have no effect until next frame.
REQ-017 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-018 IDLE -> START on synchronized 1->0 transition of RxD while Rx_EN=1.
REQ-019 START: at 8th tick, RxD=0 -> DATA; RxD=1 -> IDLE (glitch rejected, no output pulse).
REQ-020 DATA: every 16 ticks (mid-bit) shift in one bit LSB first; after 8th bit -> PARITY.
REQ-021 PARITY: after 16 ticks sample parity bit; perr = XOR(data bits, parity bit) -> STOP.
REQ-022 STOP: after 16 ticks sample stop bit -> IDLE.
REQ-023 Cycle after stop sample: no error -> Rx_DATA loaded, Rx_VALID=1 one cycle.
REQ-024 Parity error -> Rx_PERROR=1 one cycle; stop=0 -> Rx_FERROR=1 one cycle; both may assert together; on any error Rx_VALID=0 and Rx_DATA unchanged.
REQ-025 Rx_BUSY=1 in START, DATA, PARITY, STOP; 0 in IDLE.
REQ-026 Rx_EN=0 in any state -> IDLE next cycle, no pulses, Rx_DATA unchanged.
REQ-027 After framing error, new start SHALL need RxD to return high then fall (edge-detect).
REQ-028 A start edge arriving in the cycle the FSM returns to IDLE SHALL be detected.

Reset
REQ-029 On reset: FSM=IDLE, Rx_DATA=8'h00, Rx_VALID=0, Rx_PERROR=0, Rx_FERROR=0, Rx_BUSY=0, counters=0, synchronizer flops=1.
REQ-030 Reset mid-frame SHALL abort frame with no output pulses; reception resumes on next falling edge after release.

Verification
REQ-031 Code 7, send 0xA5 parity 0 stop 1 -> one Rx_VALID pulse, Rx_DATA=8'hA5, no error pulses.
REQ-032 Code 3, send 0x01 with parity 0 (wrong) -> Rx_PERROR pulse, no Rx_VALID, Rx_DATA keeps prior value.
REQ-033 Code 7, send 0x3C with stop bit 0 -> Rx_FERROR pulse; following valid 0x55 frame -> Rx_DATA=8'h55.
REQ-034 RxD low pulse of 4 sample ticks at code 7 -> Rx_BUSY high then low, no output pulses.
REQ-035 Drop Rx_EN during DATA bit 4 -> Rx_BUSY=0 next cycle, no pulses; re-enable, send 0xFF -> Rx_DATA=8'hFF.
REQ-036 Assert reset mid-frame of 0x81 -> all outputs 0 immediately; back-to-back 0x12,0x34 after release -> two Rx_VALID pulses, values in order.
